hwt_output_monitor: RTL and testbench

//  Runtime checker on the receiving side of the non_active_hwt gate-level cell.

---
 rtl/hwt_output_monitor.sv | 131 +++++++++++++
 tb/tb_hwt_output_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hwt_output_monitor.sv
// Runtime checker for the non_active_hwt cell: recomputes Y = D & ((A & B) | C), counts mismatches
// and trigger vectors, raises a sticky alarm. Optional first-mismatch log under HWT_MON_LOG_EN.
module hwt_output_monitor #(
    parameter int CNT_W     = 8,
    parameter int MM_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             y_dut,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] mm_cnt,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [1:0]       state
`ifdef HWT_MON_LOG_EN
    ,
    output logic             log_valid,
    output logic [4:0]       log_vec
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(MM_THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           cur, nxt;
    logic             rst_meta, rst_int;
    logic             a1, b1, c1, d1, y1, v1;
    logic             clr_q;
    logic             y_ref, mm_now, trig_now, clr_rise, clear_now;
    logic [CNT_W-1:0] mm_next, trig_next;

    // Reset asserts asynchronously but releases two clocks after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta <= 1'b1;
            rst_int  <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_int  <= rst_meta;
        end
    end

    assign y_ref     = d1 & ((a1 & b1) | c1);
    assign mm_now    = v1 & (y_ref ^ y1);
    assign trig_now  = v1 & a1 & b1 & c1 & d1;
    assign clr_rise  = clr_req & ~clr_q;
    assign clear_now = clr_rise & (cur != CLEAR);
    assign mm_next   = clear_now ? '0 : (mm_now   ? sat_inc(mm_cnt)   : mm_cnt);
    assign trig_next = clear_now ? '0 : (trig_now ? sat_inc(trig_cnt) : trig_cnt);
    assign state     = cur;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:    if (!clear_now && en) nxt = MONITOR;
            MONITOR: begin
                if (!clear_now) begin
                    if (mm_next >= THRESH) nxt = ALARM;
                    else if (!en)          nxt = IDLE;
                end
            end
            ALARM:   if (clear_now) nxt = CLEAR;
            CLEAR:   nxt = en ? MONITOR : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            cur      <= IDLE;
            a1       <= 1'b0;
            b1       <= 1'b0;
            c1       <= 1'b0;
            d1       <= 1'b0;
            y1       <= 1'b0;
            v1       <= 1'b0;
            clr_q    <= 1'b0;
            mm_cnt   <= '0;
            trig_cnt <= '0;
            mismatch <= 1'b0;
            clr_ack  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            cur      <= nxt;
            {a1, b1, c1, d1, y1} <= {a, b, c, d, y_dut};
            v1       <= en & ~clear_now;
            clr_q    <= clr_req;
            mm_cnt   <= mm_next;
            trig_cnt <= trig_next;
            mismatch <= mm_now & ~clear_now;
            clr_ack  <= clear_now;
            alarm    <= (nxt == ALARM);
        end
    end

`ifdef HWT_MON_LOG_EN
    // Only the first mismatch since the last clear is kept.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            log_valid <= 1'b0;
            log_vec   <= '0;
        end else if (clear_now) begin
            log_valid <= 1'b0;
            log_vec   <= '0;
        end else if (mm_now && !log_valid) begin
            log_valid <= 1'b1;
            log_vec   <= {a1, b1, c1, d1, y1};
        end
    end
`endif

endmodule

// File: tb/tb_hwt_output_monitor.sv
// Directed self-checking bench for hwt_output_monitor (CNT_W=8, MM_THRESH=3).
// Log checks are compiled in when HWT_MON_LOG_EN is defined.
module tb_hwt_output_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic       a, b, c, d, y_dut;
    logic       clr_req;
    logic       clr_ack, mismatch, alarm;
    logic [7:0] mm_cnt, trig_cnt;
    logic [1:0] state;
`ifdef HWT_MON_LOG_EN
    logic       log_valid;
    logic [4:0] log_vec;
`endif

    int compared = 0;
    int mismatched = 0;

    hwt_output_monitor #(.CNT_W(8), .MM_THRESH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .y_dut    (y_dut),
        .clr_req  (clr_req),
        .clr_ack  (clr_ack),
        .mismatch (mismatch),
        .alarm    (alarm),
        .mm_cnt   (mm_cnt),
        .trig_cnt (trig_cnt),
        .state    (state)
`ifdef HWT_MON_LOG_EN
        ,
        .log_valid(log_valid),
        .log_vec  (log_vec)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic yv);
        {a, b, c, d} = v;
        y_dut = yv;
    endtask

    // Present one sample, then flush with a golden 0000 sample so the compare becomes visible.
    task automatic inject(input logic [3:0] v, input logic yv);
        drive(v, yv);
        tick();
        drive(4'b0000, 1'b0);
        tick();
    endtask

    function automatic logic golden(input logic [3:0] v);
        return v[0] & ((v[3] & v[2]) | v[1]);
    endfunction

    initial begin
        rst = 1'b1;
        en = 1'b0;
        clr_req = 1'b0;
        drive(4'b0000, 1'b0);
        tick();
        tick();
        check("rst_state",    32'(state),    32'd0);
        check("rst_mm_cnt",   32'(mm_cnt),   32'd0);
        check("rst_trig_cnt", 32'(trig_cnt), 32'd0);
        check("rst_alarm",    32'(alarm),    32'd0);
        check("rst_clr_ack",  32'(clr_ack),  32'd0);

        // 1: golden sweep
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("idle_after_rst", 32'(state), 32'd0);
        en = 1'b1;
        tick();
        check("to_monitor", 32'(state), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), golden(4'(i)));
            tick();
            check("sweep_mismatch", 32'(mismatch), 32'd0);
        end
        drive(4'b0000, 1'b0);
        tick();
        check("sweep_mm_cnt",   32'(mm_cnt),   32'd0);
        check("sweep_trig_cnt", 32'(trig_cnt), 32'd1);
        check("sweep_state",    32'(state),    32'd1);

        // 2: three mismatches reach the threshold
        for (int k = 1; k <= 3; k++) begin
            inject(4'b1111, 1'b0);
            check("inj_mismatch", 32'(mismatch), 32'd1);
            check("inj_mm_cnt",   32'(mm_cnt),   32'(k));
            check("inj_alarm",    32'(alarm),    (k == 3) ? 32'd1 : 32'd0);
            check("inj_state",    32'(state),    (k == 3) ? 32'd2 : 32'd1);
            tick();
            check("inj_pulse_end", 32'(mismatch), 32'd0);
        end
        check("inj_trig_cnt", 32'(trig_cnt), 32'd4);

        // 3: clear from ALARM, held request clears only once
        clr_req = 1'b1;
        tick();
        check("clr_state",    32'(state),    32'd3);
        check("clr_ack",      32'(clr_ack),  32'd1);
        check("clr_mm_cnt",   32'(mm_cnt),   32'd0);
        check("clr_trig_cnt", 32'(trig_cnt), 32'd0);
        check("clr_alarm",    32'(alarm),    32'd0);
        tick();
        check("post_clr_state", 32'(state),   32'd1);
        check("post_clr_ack",   32'(clr_ack), 32'd0);
        inject(4'b1111, 1'b1);
        check("held_clr_ack",  32'(clr_ack),  32'd0);
        check("held_trig_cnt", 32'(trig_cnt), 32'd1);
        clr_req = 1'b0;
        tick();
        clr_req = 1'b1;
        tick();
        check("reclr_ack",      32'(clr_ack),  32'd1);
        check("reclr_trig_cnt", 32'(trig_cnt), 32'd0);
        check("reclr_state",    32'(state),    32'd1);
        clr_req = 1'b0;
        tick();

        // 4: trigger counter saturation
        drive(4'b1111, 1'b1);
        for (int i = 0; i < 300; i++) tick();
        drive(4'b0000, 1'b0);
        tick();
        tick();
        check("sat_trig_cnt", 32'(trig_cnt), 32'd255);
        check("sat_mm_cnt",   32'(mm_cnt),   32'd0);
        check("sat_state",    32'(state),    32'd1);

        // 5: en ignored in ALARM; mismatch on the clear edge is discarded
        clr_req = 1'b1;
        tick();
        check("pre5_trig_cnt", 32'(trig_cnt), 32'd0);
        clr_req = 1'b0;
        tick();
        inject(4'b1111, 1'b0);
        inject(4'b1111, 1'b0);
        inject(4'b1111, 1'b0);
        check("t5_alarm_state", 32'(state), 32'd2);
        en = 1'b0;
        tick();
        tick();
        check("en0_alarm", 32'(alarm), 32'd1);
        check("en0_state", 32'(state), 32'd2);
        en = 1'b1;
        drive(4'b1111, 1'b0);
        tick();
        clr_req = 1'b1;
        drive(4'b0000, 1'b0);
        tick();
        check("clr_edge_state",    32'(state),    32'd3);
        check("clr_edge_mm_cnt",   32'(mm_cnt),   32'd0);
        check("clr_edge_mismatch", 32'(mismatch), 32'd0);
        clr_req = 1'b0;
        tick();
        check("after_clr_state",  32'(state),  32'd1);
        check("after_clr_mm_cnt", 32'(mm_cnt), 32'd0);

        // 6: first-mismatch log, then reset mid-ALARM
        inject(4'b1111, 1'b0);
        inject(4'b0011, 1'b0);
        inject(4'b0011, 1'b0);
        check("t6_state",    32'(state),    32'd2);
        check("t6_mm_cnt",   32'(mm_cnt),   32'd3);
        check("t6_trig_cnt", 32'(trig_cnt), 32'd1);
`ifdef HWT_MON_LOG_EN
        check("log_valid", 32'(log_valid), 32'd1);
        check("log_vec",   32'(log_vec),   32'h1E);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("midrst_state",    32'(state),    32'd0);
        check("midrst_alarm",    32'(alarm),    32'd0);
        check("midrst_mm_cnt",   32'(mm_cnt),   32'd0);
        check("midrst_trig_cnt", 32'(trig_cnt), 32'd0);
        check("midrst_mismatch", 32'(mismatch), 32'd0);
        check("midrst_clr_ack",  32'(clr_ack),  32'd0);
`ifdef HWT_MON_LOG_EN
        check("midrst_log_valid", 32'(log_valid), 32'd0);
        check("midrst_log_vec",   32'(log_vec),   32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
